// File: rtl/pmem_write_buffer_if.sv
// Bus bundle between the cache arbiter, the write-back buffer and physical memory.
// The slave modport is the buffer's view; the master modport is the surrounding environment.
interface pmem_write_buffer_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
        output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
        input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_write_buffer.sv
// Write-back buffer: absorbs dirty-line writebacks into a small FIFO, serves read hits
// from it, forwards read misses to memory and drains entries when upstream is idle.
module pmem_write_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pmem_write_buffer_if.slave   bus,
    output logic                 wb_empty,
    output logic                 wb_full
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ_MEM = 2'd1,
        DRAIN    = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [LINE_W-1:0] ent_line_q [DEPTH];
    logic [DEPTH-1:0]  ent_valid_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              mem_resp_q;
    logic [LINE_W-1:0] mem_rdata_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [ADDR_W-1:0] pmem_address_q;
    logic [LINE_W-1:0] pmem_wdata_q;

    logic              hit_c;
    logic [PTR_W-1:0]  hit_idx_c;
    logic              full_c;
    logic              rd_hit_c, rd_start_c, rd_done_c;
    logic              wr_hit_c, wr_alloc_c;
    logic              drain_start_c, drain_done_c;

    assign full_c   = (count_q == CNT_W'(DEPTH));
    assign wb_empty = (count_q == '0);
    assign wb_full  = full_c;

    assign bus.mem_resp     = mem_resp_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;

    // Associative lookup; coalescing keeps at most one valid entry per address.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i] && (ent_addr_q[i] == bus.mem_address)) begin
                hit_c     = 1'b1;
                hit_idx_c = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle action strobes; a simultaneous read and write is taken as a read.
    always_comb begin
        state_d       = state_q;
        rd_hit_c      = 1'b0;
        rd_start_c    = 1'b0;
        rd_done_c     = 1'b0;
        wr_hit_c      = 1'b0;
        wr_alloc_c    = 1'b0;
        drain_start_c = 1'b0;
        drain_done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_read) begin
                    if (hit_c) begin
                        rd_hit_c = 1'b1;
                        state_d  = RESP;
                    end else begin
                        rd_start_c = 1'b1;
                        state_d    = READ_MEM;
                    end
                end else if (bus.mem_write) begin
                    if (hit_c) begin
                        wr_hit_c = 1'b1;
                        state_d  = RESP;
                    end else if (!full_c) begin
                        wr_alloc_c = 1'b1;
                        state_d    = RESP;
                    end else begin
                        drain_start_c = 1'b1;
                        state_d       = DRAIN;
                    end
                end else if (count_q != '0) begin
                    drain_start_c = 1'b1;
                    state_d       = DRAIN;
                end
            end
            READ_MEM: begin
                if (bus.pmem_resp) begin
                    rd_done_c = 1'b1;
                    state_d   = RESP;
                end
            end
            DRAIN: begin
                if (bus.pmem_resp) begin
                    drain_done_c = 1'b1;
                    state_d      = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            ent_valid_q    <= '0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            mem_resp_q <= (state_d == RESP);

            if (rd_hit_c) begin
                mem_rdata_q <= ent_line_q[hit_idx_c];
            end else if (rd_done_c) begin
                mem_rdata_q <= bus.pmem_rdata;
            end

            if (wr_alloc_c) begin
                ent_valid_q[tail_q] <= 1'b1;
                tail_q              <= tail_q + PTR_W'(1);
                count_q             <= count_q + CNT_W'(1);
            end else if (drain_done_c) begin
                ent_valid_q[head_q] <= 1'b0;
                head_q              <= head_q + PTR_W'(1);
                count_q             <= count_q - CNT_W'(1);
            end

            if (rd_start_c) begin
                pmem_read_q    <= 1'b1;
                pmem_address_q <= bus.mem_address;
                pmem_wdata_q   <= '0;
            end else if (drain_start_c) begin
                pmem_write_q   <= 1'b1;
                pmem_address_q <= ent_addr_q[head_q];
                pmem_wdata_q   <= ent_line_q[head_q];
            end else if (rd_done_c || drain_done_c) begin
                pmem_read_q    <= 1'b0;
                pmem_write_q   <= 1'b0;
                pmem_address_q <= '0;
                pmem_wdata_q   <= '0;
            end
        end
    end

    // Entry payload storage; validity is tracked separately so this needs no reset.
    always_ff @(posedge clk) begin
        if (wr_alloc_c) begin
            ent_addr_q[tail_q] <= bus.mem_address;
            ent_line_q[tail_q] <= bus.mem_wdata;
        end else if (wr_hit_c) begin
            ent_line_q[hit_idx_c] <= bus.mem_wdata;
        end
    end
endmodule

// File: tb/tb_pmem_write_buffer.sv
// Self-checking bench for pmem_write_buffer: directed sequences, a vector table and
// randomized traffic against a queue-plus-memory reference model.
module tb_pmem_write_buffer;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic wb_empty, wb_full;

    always #5 clk = ~clk;

    pmem_write_buffer_if bus ();

    pmem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .wb_empty (wb_empty),
        .wb_full  (wb_full)
    );

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] line;
    } ent_t;

    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] line;
        int           lat;
        int           exp_edges;
        int           exp_rdcyc;
        logic [127:0] exp_rdata;
        bit           exp_empty;
        bit           exp_full;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int lat    = 2;
    int resp_cnt = 0;
    int rd_strobe_total = 0;

    ent_t         model_q [$];
    logic [127:0] mem_model [logic [15:0]];
    ent_t         drain_log [$];

    function automatic logic [127:0] init_line(input logic [15:0] a);
        return {8{a ^ 16'hA5C3}};
    endfunction

    function automatic logic [127:0] mem_val(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return init_line(a);
    endfunction

    // What upstream must see: newest buffered copy, otherwise memory.
    function automatic logic [127:0] exp_read(input logic [15:0] a);
        foreach (model_q[k]) if (model_q[k].addr == a) return model_q[k].line;
        return mem_val(a);
    endfunction

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Memory model: responds in the lat-th cycle a strobe is seen, logs and checks drains.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                resp_cnt      = 0;
                bus.pmem_resp = 1'b0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                resp_cnt      = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                resp_cnt++;
                if (resp_cnt >= lat) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read) begin
                        bus.pmem_rdata = mem_val(bus.pmem_address);
                    end else begin
                        drain_log.push_back('{bus.pmem_address, bus.pmem_wdata});
                        checks++;
                        if (model_q.size() == 0) begin
                            errors++;
                            $display("FAIL drain_unexpected actual=addr %h required=no drain", bus.pmem_address);
                        end else begin
                            if (bus.pmem_address !== model_q[0].addr || bus.pmem_wdata !== model_q[0].line) begin
                                errors++;
                                $display("FAIL drain_order actual=%h/%h required=%h/%h", bus.pmem_address,
                                         bus.pmem_wdata, model_q[0].addr, model_q[0].line);
                            end
                            void'(model_q.pop_front());
                        end
                        mem_model[bus.pmem_address] = bus.pmem_wdata;
                    end
                end
            end
        end
    end

    // Strobe exclusivity and quiet-bus rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.pmem_read) rd_strobe_total++;
        checks++;
        if ((bus.pmem_read && bus.pmem_write) ||
            (!bus.pmem_read && !bus.pmem_write && (bus.pmem_address != '0 || bus.pmem_wdata != '0))) begin
            errors++;
            $display("FAIL pmem_strobes actual=rd%0b wr%0b addr=%h required=exclusive strobes, zero bus when idle",
                     bus.pmem_read, bus.pmem_write, bus.pmem_address);
        end
    end

    // One upstream transaction; starts just after an edge, ends one cycle after mem_resp.
    task automatic do_op(input bit wr, input logic [15:0] a, input logic [127:0] d,
                         output logic [127:0] rd, output int edges, output int rdcyc);
        bit found;
        bus.mem_read    = !wr;
        bus.mem_write   = wr;
        bus.mem_address = a;
        bus.mem_wdata   = d;
        edges = 0;
        rdcyc = 0;
        while (1) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.pmem_read) rdcyc++;
            if (bus.mem_resp || edges >= 300) break;
        end
        if (!bus.mem_resp) begin
            checks++;
            errors++;
            $display("FAIL op_timeout addr=%h actual=no mem_resp required=mem_resp", a);
        end
        rd = bus.mem_rdata;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        if (wr && bus.mem_resp) begin
            found = 1'b0;
            foreach (model_q[k]) begin
                if (model_q[k].addr == a) begin
                    model_q[k].line = d;
                    found = 1'b1;
                end
            end
            if (!found) model_q.push_back('{a, d});
        end
        @(posedge clk);
        #1;
        chk_int("mem_resp_one_cycle", int'(bus.mem_resp), 0);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!wb_empty && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_int(name, int'(wb_empty), 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] L1 = {4{32'h1111_1111}};
    localparam logic [127:0] L2 = {4{32'h2222_2222}};
    localparam logic [127:0] LA = {4{32'hAAAA_0001}};
    localparam logic [127:0] LB = {4{32'hBBBB_0002}};
    localparam logic [127:0] LC = {4{32'hCCCC_0003}};
    localparam logic [127:0] LD = {4{32'hDDDD_0004}};
    localparam logic [127:0] LE = {4{32'hEEEE_0005}};

    vec_t tbl [9];

    initial begin
        logic [127:0] rd;
        int           edges, rdcyc, base;
        logic [15:0]  a;
        logic [127:0] d;
        bit           wr;

        tbl[0] = '{1'b1, 16'h0030, LA, 3, 1, 0, '0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'h0040, LB, 3, 1, 0, '0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 16'h0030, '0, 3, 1, 0, LA, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'h0040, LC, 3, 1, 0, '0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 16'h0050, LD, 3, 5, 0, '0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 16'h0040, '0, 3, 1, 0, LC, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'h0100, '0, 5, 6, 5, init_line(16'h0100), 1'b0, 1'b1};
        tbl[7] = '{1'b1, 16'h0060, LE, 2, 4, 0, '0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 16'h0030, '0, 1, 2, 1, LA, 1'b0, 1'b1};

        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        rst_n           = 1'b0;
        #2;
        chk_int("reset_mem_resp", int'(bus.mem_resp), 0);
        chk128("reset_mem_rdata", bus.mem_rdata, '0);
        chk_int("reset_pmem_read", int'(bus.pmem_read), 0);
        chk_int("reset_pmem_write", int'(bus.pmem_write), 0);
        chk128("reset_pmem_address", 128'(bus.pmem_address), '0);
        chk128("reset_pmem_wdata", bus.pmem_wdata, '0);
        chk_int("reset_wb_empty", int'(wb_empty), 1);
        chk_int("reset_wb_full", int'(wb_full), 0);
        apply_reset();

        // Single write, acknowledged next cycle, then drained while idle.
        lat = 2;
        drain_log.delete();
        do_op(1'b1, 16'h0010, L1, rd, edges, rdcyc);
        chk_int("write_accept_latency", edges, 1);
        chk_int("write_not_empty", int'(wb_empty), 0);
        wait_empty("idle_drain_empties");
        chk_int("idle_drain_count", drain_log.size(), 1);
        if (drain_log.size() >= 1) begin
            chk128("idle_drain_addr", 128'(drain_log[0].addr), 128'(16'h0010));
            chk128("idle_drain_line", drain_log[0].line, L1);
        end

        // Coalescing: second write to the same line overwrites in place.
        drain_log.delete();
        do_op(1'b1, 16'h0020, L1, rd, edges, rdcyc);
        do_op(1'b1, 16'h0020, L2, rd, edges, rdcyc);
        chk_int("coalesce_not_full", int'(wb_full), 0);
        wait_empty("coalesce_drained");
        chk_int("coalesce_drain_count", drain_log.size(), 1);
        if (drain_log.size() >= 1) chk128("coalesce_drain_line", drain_log[0].line, L2);

        // Vector table, issued back to back so no idle drains interleave.
        drain_log.delete();
        for (int i = 0; i < 9; i++) begin
            lat = tbl[i].lat;
            do_op(tbl[i].wr, tbl[i].addr, tbl[i].line, rd, edges, rdcyc);
            chk_int($sformatf("vec%0d_edges", i), edges, tbl[i].exp_edges);
            chk_int($sformatf("vec%0d_pmem_read_cycles", i), rdcyc, tbl[i].exp_rdcyc);
            if (!tbl[i].wr) chk128($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk_int($sformatf("vec%0d_empty", i), int'(wb_empty), int'(tbl[i].exp_empty));
            chk_int($sformatf("vec%0d_full", i), int'(wb_full), int'(tbl[i].exp_full));
        end
        lat = 2;
        wait_empty("table_drained");
        chk_int("table_drain_count", drain_log.size(), 4);
        if (drain_log.size() == 4) begin
            chk128("table_drain0", 128'(drain_log[0].addr), 128'(16'h0030));
            chk128("table_drain1", 128'(drain_log[1].addr), 128'(16'h0040));
            chk128("table_drain1_line", drain_log[1].line, LC);
            chk128("table_drain2", 128'(drain_log[2].addr), 128'(16'h0050));
            chk128("table_drain3", 128'(drain_log[3].addr), 128'(16'h0060));
        end

        // Randomized traffic over a small address set against the reference model.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            lat = int'($urandom_range(1, 4));
            wr  = 1'($urandom_range(0, 1));
            a   = 16'h0200 + 16'($urandom_range(0, 5));
            d   = {$urandom, $urandom, $urandom, $urandom};
            do_op(wr, a, d, rd, edges, rdcyc);
            if (!wr) chk128($sformatf("rand%0d_rdata_%h", i, a), rd, exp_read(a));
        end
        lat = 2;
        wait_empty("random_drained");
        chk_int("random_model_empty", model_q.size(), 0);

        // Read hit with memory stalled, then reset in the middle of the resulting drain.
        lat  = 1000;
        base = rd_strobe_total;
        do_op(1'b1, 16'h0010, L1, rd, edges, rdcyc);
        do_op(1'b0, 16'h0010, '0, rd, edges, rdcyc);
        chk128("stalled_hit_rdata", rd, L1);
        chk_int("stalled_hit_no_pmem_read", rd_strobe_total - base, 0);
        edges = 0;
        while (!bus.pmem_write && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk_int("stalled_drain_started", int'(bus.pmem_write), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_int("reset_drops_pmem_write", int'(bus.pmem_write), 0);
        chk_int("reset_empties", int'(wb_empty), 1);
        model_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat   = 2;
        drain_log.delete();
        repeat (10) @(posedge clk);
        #1;
        chk_int("post_reset_no_drain", drain_log.size(), 0);
        chk_int("post_reset_empty", int'(wb_empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
